// File: rtl/dsp48a1_mac_sequencer_if.sv
// Operand and result handshake bundle between the producer/consumer and the MAC sequencer.
interface dsp48a1_mac_sequencer_if;
   logic        in_valid;
   logic        in_ready;
   logic [17:0] in_a;
   logic [17:0] in_b;
   logic        res_valid;
   logic        res_ready;
   logic [47:0] res_data;

   modport master (
      output in_valid, in_a, in_b, res_ready,
      input  in_ready, res_valid, res_data
   );

   modport slave (
      input  in_valid, in_a, in_b, res_ready,
      output in_ready, res_valid, res_data
   );
endinterface

// File: rtl/dsp48a1_mac_sequencer.sv
// Sequences one DSP48A1 slice as a dot-product engine with pipeline-aligned OPMODE control.
// Optional perf counters (perf_jobs, perf_bubbles) are enabled by defining DSP_SEQ_PERF_EN.
module dsp48a1_mac_sequencer #(
   parameter int unsigned LEN_W  = 8,
   parameter int unsigned AB_LAT = 1,
   parameter int unsigned M_LAT  = 1,
   parameter int unsigned P_LAT  = 1,
   parameter int unsigned OP_LAT = 1
) (
   input  logic                   CLK,
   input  logic                   RST_N,
   input  logic                   start,
   input  logic [LEN_W-1:0]       cfg_len,
   output logic                   busy,
   output logic                   len_err,
   dsp48a1_mac_sequencer_if.slave bus,
   output logic [17:0]            dsp_a,
   output logic [17:0]            dsp_b,
   output logic [7:0]             dsp_opmode,
   output logic                   dsp_ce,
`ifdef DSP_SEQ_PERF_EN
   output logic [31:0]            perf_jobs,
   output logic [31:0]            perf_bubbles,
`endif
   input  logic [47:0]            dsp_p
);

   localparam int unsigned L   = AB_LAT + M_LAT;
   localparam int unsigned OPD = L - OP_LAT;
   localparam int unsigned TD  = L + P_LAT;

   localparam logic [7:0] OpFirst = 8'h01;
   localparam logic [7:0] OpAcc   = 8'h09;
   localparam logic [7:0] OpHold  = 8'h08;

   typedef enum logic [1:0] {StIdle, StIssue, StDrain, StDone} state_e;

   state_e           state_q, state_d;
   logic [LEN_W-1:0] len_q, len_d;
   logic [LEN_W-1:0] cnt_q, cnt_d;
   logic             busy_q, busy_d;
   logic             in_ready_q, in_ready_d;
   logic             res_valid_q, res_valid_d;
   logic [47:0]      res_data_q, res_data_d;
   logic             len_err_q, len_err_d;
   logic [17:0]      a_q, a_d;
   logic [17:0]      b_q, b_d;
   logic             ce_q, ce_d;
   // Stage 0 is the issue register; the last stage drives the slice OPMODE pin.
   logic [OPD:0][7:0] op_q, op_d;
   logic [TD:0]      last_q, last_d;
   logic             beat;
   logic [7:0]       issue_op;
   logic             issue_last;
`ifdef DSP_SEQ_PERF_EN
   logic [31:0]      jobs_q, jobs_d;
   logic [31:0]      bubbles_q, bubbles_d;
`endif

   assign beat = (state_q == StIssue) && bus.in_valid && in_ready_q;

   always_comb begin
      state_d     = state_q;
      len_d       = len_q;
      cnt_d       = cnt_q;
      res_data_d  = res_data_q;
      len_err_d   = 1'b0;
      a_d         = '0;
      b_d         = '0;
      issue_op    = 8'h00;
      issue_last  = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (start) begin
               if (cfg_len != '0) begin
                  len_d   = cfg_len;
                  cnt_d   = '0;
                  state_d = StIssue;
               end else begin
                  len_err_d = 1'b1;
               end
            end
         end
         StIssue: begin
            issue_op = OpHold;
            if (beat) begin
               a_d      = bus.in_a;
               b_d      = bus.in_b;
               issue_op = (cnt_q == '0) ? OpFirst : OpAcc;
               cnt_d    = cnt_q + 1'b1;
               if (cnt_q == len_q - 1'b1) begin
                  issue_last = 1'b1;
                  state_d    = StDrain;
               end
            end
         end
         StDrain: begin
            issue_op = OpHold;
            if (last_q[TD]) begin
               res_data_d = dsp_p;
               state_d    = StDone;
            end
         end
         StDone: begin
            if (res_valid_q && bus.res_ready) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase

      busy_d      = (state_d != StIdle);
      in_ready_d  = (state_d == StIssue);
      ce_d        = (state_d == StIssue) || (state_d == StDrain);
      res_valid_d = (state_d == StDone);

      op_d[0] = issue_op;
      for (int i = 1; i <= int'(OPD); i++) begin
         op_d[i] = op_q[i-1];
      end
      last_d[0] = issue_last;
      for (int i = 1; i <= int'(TD); i++) begin
         last_d[i] = last_q[i-1];
      end

`ifdef DSP_SEQ_PERF_EN
      jobs_d    = jobs_q;
      bubbles_d = bubbles_q;
      if (state_q == StDone && res_valid_q && bus.res_ready) begin
         jobs_d = jobs_q + 32'd1;
      end
      if (state_q == StIssue && !beat) begin
         bubbles_d = bubbles_q + 32'd1;
      end
`endif
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q     <= StIdle;
         len_q       <= '0;
         cnt_q       <= '0;
         busy_q      <= 1'b0;
         in_ready_q  <= 1'b0;
         res_valid_q <= 1'b0;
         res_data_q  <= '0;
         len_err_q   <= 1'b0;
         a_q         <= '0;
         b_q         <= '0;
         ce_q        <= 1'b0;
         op_q        <= '0;
         last_q      <= '0;
`ifdef DSP_SEQ_PERF_EN
         jobs_q      <= '0;
         bubbles_q   <= '0;
`endif
      end else begin
         state_q     <= state_d;
         len_q       <= len_d;
         cnt_q       <= cnt_d;
         busy_q      <= busy_d;
         in_ready_q  <= in_ready_d;
         res_valid_q <= res_valid_d;
         res_data_q  <= res_data_d;
         len_err_q   <= len_err_d;
         a_q         <= a_d;
         b_q         <= b_d;
         ce_q        <= ce_d;
         op_q        <= op_d;
         last_q      <= last_d;
`ifdef DSP_SEQ_PERF_EN
         jobs_q      <= jobs_d;
         bubbles_q   <= bubbles_d;
`endif
      end
   end

   assign busy          = busy_q;
   assign len_err       = len_err_q;
   assign bus.in_ready  = in_ready_q;
   assign bus.res_valid = res_valid_q;
   assign bus.res_data  = res_data_q;
   assign dsp_a         = a_q;
   assign dsp_b         = b_q;
   assign dsp_opmode    = op_q[OPD];
   assign dsp_ce        = ce_q;
`ifdef DSP_SEQ_PERF_EN
   assign perf_jobs     = jobs_q;
   assign perf_bubbles  = bubbles_q;
`endif

endmodule
